dual_mux_4_to_1: RTL and testbench

- Dual 4-to-1 data selector with the same function as a 74LS153.
- Two independent sections share one 2-bit select (A1,A0). Each section has its own active-low strobe.
- Combinational outputs Y1/Y2 drive glue logic in the 74LSXX library.
- A registered copy Y1_q/Y2_q, clocked by clk and cleared by rst, gives synchronous consumers a glitch-free version.

---
 rtl/dual_mux_4_to_1.sv | 83 ++++++++
 tb/tb_dual_mux_4_to_1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dual_mux_4_to_1.sv
// Dual 4-to-1 data selector (74LS153 function) with registered output copies.
// Optional define DUAL_MUX_XOR_EN adds a registered Y1^Y2 output Yx_q.
module dual_mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S1_n,
  input  logic             S2_n,
  input  logic             A1,
  input  logic             A0,
  input  logic [WIDTH-1:0] D0_1,
  input  logic [WIDTH-1:0] D1_1,
  input  logic [WIDTH-1:0] D2_1,
  input  logic [WIDTH-1:0] D3_1,
  input  logic [WIDTH-1:0] D0_2,
  input  logic [WIDTH-1:0] D1_2,
  input  logic [WIDTH-1:0] D2_2,
  input  logic [WIDTH-1:0] D3_2,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y1_q,
  output logic [WIDTH-1:0] Y2_q
`ifdef DUAL_MUX_XOR_EN
  ,
  output logic [WIDTH-1:0] Yx_q
`endif
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y1_d;
  logic [WIDTH-1:0] y2_d;

  assign sel = {A1, A0};

  // Strobe is tested first so a disabled section reads 0 even with X on select or data.
  always_comb begin
    y1_d = '0;
    if (!S1_n) begin
      case (sel)
        2'b00:   y1_d = D0_1;
        2'b01:   y1_d = D1_1;
        2'b10:   y1_d = D2_1;
        2'b11:   y1_d = D3_1;
        default: y1_d = 'x;
      endcase
    end
  end

  always_comb begin
    y2_d = '0;
    if (!S2_n) begin
      case (sel)
        2'b00:   y2_d = D0_2;
        2'b01:   y2_d = D1_2;
        2'b10:   y2_d = D2_2;
        2'b11:   y2_d = D3_2;
        default: y2_d = 'x;
      endcase
    end
  end

  assign Y1 = y1_d;
  assign Y2 = y2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y1_q <= '0;
      Y2_q <= '0;
    end else begin
      Y1_q <= y1_d;
      Y2_q <= y2_d;
    end
  end

`ifdef DUAL_MUX_XOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Yx_q <= '0;
    else     Yx_q <= y1_d ^ y2_d;
  end
`endif

endmodule

// File: tb/tb_dual_mux_4_to_1.sv
// Directed-vector bench for dual_mux_4_to_1; define DUAL_MUX_XOR_EN to cover Yx_q.
module tb_dual_mux_4_to_1;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         S1_n, S2_n, A1, A0;
  logic [W-1:0] D0_1, D1_1, D2_1, D3_1;
  logic [W-1:0] D0_2, D1_2, D2_2, D3_2;
  logic [W-1:0] Y1, Y2, Y1_q, Y2_q;
`ifdef DUAL_MUX_XOR_EN
  logic [W-1:0] Yx_q;
`endif

  int total = 0;
  int bad   = 0;

  dual_mux_4_to_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .S1_n(S1_n), .S2_n(S2_n), .A1(A1), .A0(A0),
    .D0_1(D0_1), .D1_1(D1_1), .D2_1(D2_1), .D3_1(D3_1),
    .D0_2(D0_2), .D1_2(D1_2), .D2_2(D2_2), .D3_2(D3_2),
    .Y1(Y1), .Y2(Y2), .Y1_q(Y1_q), .Y2_q(Y2_q)
`ifdef DUAL_MUX_XOR_EN
    , .Yx_q(Yx_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    logic [7:0]   pat1, pat2;
    logic [W-1:0] e1, e2;

    rst = 1'b1; S1_n = 1'b1; S2_n = 1'b1; A1 = 1'b0; A0 = 1'b0;
    {D0_1, D1_1, D2_1, D3_1, D0_2, D1_2, D2_2, D3_2} = '0;
    #2;
    check("rst_y1q", Y1_q, 1'b0);
    check("rst_y2q", Y2_q, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Both sections disabled: outputs stay 0 whatever select and data do.
    for (int i = 0; i < 8; i++) begin
      {A1, A0} = i[1:0];
      {D0_1, D1_1, D2_1, D3_1, D0_2, D1_2, D2_2, D3_2} = 8'hA5 ^ (8'h3C << i);
      #1;
      check("dis_y1", Y1, 1'b0);
      check("dis_y2", Y2, 1'b0);
    end
    {D0_1, D1_1, D2_1, D3_1, D0_2, D1_2, D2_2, D3_2} = 8'hxx;
    {A1, A0} = 2'bx1;
    #1;
    check("dis_x_y1", Y1, 1'b0);
    check("dis_x_y2", Y2, 1'b0);
    @(posedge clk); #1;
    check("dis_y1q", Y1_q, 1'b0);
    check("dis_y2q", Y2_q, 1'b0);
    {D0_1, D1_1, D2_1, D3_1, D0_2, D1_2, D2_2, D3_2} = '0;

    // Enabled, select 00: D0_1 toggles every step, D0_2 every 8 steps.
    S1_n = 1'b0; S2_n = 1'b0; {A1, A0} = 2'b00;
    for (int i = 0; i < 16; i++) begin
      D0_1 = i[0];
      D0_2 = i[3];
      #1;
      check("sel00_y1", Y1, i[0]);
      check("sel00_y2", Y2, i[3]);
    end

    // Select 01/10/11 with each input on its own toggle pattern.
    for (int s = 1; s < 4; s++) begin
      {A1, A0} = s[1:0];
      for (int i = 0; i < 8; i++) begin
        pat1 = 8'b0101_0101 >> i;
        pat2 = 8'b0011_0011 >> i;
        D0_1 = ~pat1[0]; D1_1 = pat1[0]; D2_1 = pat2[0]; D3_1 = i[2];
        D0_2 = ~pat2[0]; D1_2 = i[2];    D2_2 = pat1[0]; D3_2 = i[0];
        case (s)
          1:       begin e1 = pat1[0]; e2 = i[2];    end
          2:       begin e1 = pat2[0]; e2 = pat1[0]; end
          default: begin e1 = i[2];    e2 = i[0];    end
        endcase
        #1;
        check($sformatf("sel%0d_y1", s), Y1, e1);
        check($sformatf("sel%0d_y2", s), Y2, e2);
      end
    end

    // Strobe independence.
    {D0_1, D1_1, D2_1, D3_1, D0_2, D1_2, D2_2, D3_2} = '0;
    {A1, A0} = 2'b10; D2_1 = 1'b1; D2_2 = 1'b1;
    S1_n = 1'b0; S2_n = 1'b1; #1;
    check("mix_y1", Y1, 1'b1);
    check("mix_y2", Y2, 1'b0);
    S1_n = 1'b1; S2_n = 1'b0; #1;
    check("swap_y1", Y1, 1'b0);
    check("swap_y2", Y2, 1'b1);

    // Registered path: one-edge latency.
    @(negedge clk);
    S1_n = 1'b0; S2_n = 1'b1; D2_1 = 1'b0;
    @(posedge clk); #1;
    check("reg_pre_y1q", Y1_q, 1'b0);
    D2_1 = 1'b1; #1;
    check("reg_notyet", Y1_q, 1'b0);
    @(posedge clk); #1;
    check("reg_y1q", Y1_q, 1'b1);
    check("reg_y2q", Y2_q, 1'b0);

    // Asynchronous reset mid-cycle.
    S2_n = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_y2q", Y2_q, 1'b1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("arst_y1q", Y1_q, 1'b0);
    check("arst_y2q", Y2_q, 1'b0);
    check("arst_y1", Y1, 1'b1);
    @(posedge clk); #1;
    check("hold_y1q", Y1_q, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reload_y1q", Y1_q, 1'b1);
    check("reload_y2q", Y2_q, 1'b1);

`ifdef DUAL_MUX_XOR_EN
    @(negedge clk); S2_n = 1'b1;
    @(posedge clk); #1;
    check("xor_10", Yx_q, 1'b1);
    @(negedge clk); S2_n = 1'b0;
    @(posedge clk); #1;
    check("xor_11", Yx_q, 1'b0);
    @(negedge clk); S2_n = 1'b1;
    @(posedge clk); #1;
    check("xor_10b", Yx_q, 1'b1);
    #2; rst = 1'b1; #1;
    check("xor_rst", Yx_q, 1'b0);
    @(negedge clk); rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
